// File: rtl/chunked_adder_sub.sv
// chunked_adder_sub: multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock, valid/ready on both sides
module chunked_adder_sub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  if (CHUNK < 1 || CHUNK > WIDTH || WIDTH % CHUNK != 0) begin : g_bad_params
    $error("chunked_adder_sub: WIDTH must be a multiple of CHUNK and 1 <= CHUNK <= WIDTH");
  end
  logic [1:0]       state_q;
  logic [CW-1:0]    count_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q, s_q, s_d;
  logic             c_out_q, ovf_q, zero_q;
  logic [CHUNK:0]   sum;
  logic             last;
  always_comb begin
    sum  = {1'b0, a_q[count_q*CHUNK +: CHUNK]} + {1'b0, b_q[count_q*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, carry_q};
    s_d  = s_q;
    s_d[count_q*CHUNK +: CHUNK] = sum[CHUNK-1:0];
    last = count_q == CW'(N - 1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (state_q == IDLE) begin
      if (in_valid) begin
        a_q     <= a;
        b_q     <= sub ? ~b : b;
        carry_q <= c_in ^ sub;
        count_q <= '0;
        state_q <= RUN;
      end
    end else if (state_q == RUN) begin
      s_q     <= s_d;
      carry_q <= sum[CHUNK];
      if (last) begin
        // carry into the MSB recovered from the MSB sum bit and its operands
        c_out_q <= sum[CHUNK];
        ovf_q   <= a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ s_d[WIDTH-1] ^ sum[CHUNK];
        zero_q  <= ~|s_d;
        state_q <= DONE;
      end else begin
        count_q <= count_q + CW'(1);
      end
    end else begin
      state_q <= (state_q == DONE && !out_ready) ? DONE : IDLE;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign s         = s_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
endmodule
